hwce_wmem_banked: RTL and testbench
===================================

# hwce_wmem_banked

Parametrised, word-interleaved weight memory for the HWCE. NB_BANKS single-clock dual-port banks; port A of every bank is shared by NB_DMA_PORTS DMA masters through a per-bank round-robin crossbar, port B of bank i is dedicated to weight-load port i. Replaces the fixed one-DMA-port-per-bank wrapper: arbitrates contention, routes responses back to the requester, and optionally protects stored bytes with parity.

## Interface
- DATA_WIDTH, 32: word width, multiple of 8.
- BANK_SIZE, 256: words per bank, power of two.
- NB_BANKS, 4: bank count, power of two, at least 1.
- NB_DMA_PORTS, 2: DMA master count, at least 1.
- ADDR_WIDTH, 32: DMA byte-address width.
- clk_i  in  1  single clock.
- rst_i  in  1  synchronous, active-high reset.
- dma_req_i / dma_wen_i  in  [NB_DMA_PORTS]  request; wen=1 read, 0 write.
- dma_add_i  in  [NB_DMA_PORTS][ADDR_WIDTH]  byte address.
- dma_wdata_i / dma_be_i  in  [NB_DMA_PORTS][DATA_WIDTH] / [DATA_WIDTH/8]  write data, byte enables.
- dma_gnt_o  out  [NB_DMA_PORTS]  combinational grant.
- dma_r_valid_o / dma_r_err_o  out  [NB_DMA_PORTS]  response valid, parity error.
- dma_r_rdata_o  out  [NB_DMA_PORTS][DATA_WIDTH]  read data.
- wl_req_i / wl_wen_i  in  [NB_BANKS]  weight-load request, read/write.
- wl_add_i  in  [NB_BANKS][log2 BANK_SIZE]  bank-local row.
- wl_wdata_i / wl_be_i  in  per bank  write data, byte enables.
- wl_gnt_o / wl_r_valid_o / wl_r_err_o  out  [NB_BANKS]  grant, valid, parity error.
- wl_r_rdata_o  out  [NB_BANKS][DATA_WIDTH]  read data.

## Operation
- DMA decode: word = add >> log2(DATA_WIDTH/8); bank = word mod NB_BANKS; row = (word / NB_BANKS) mod BANK_SIZE. Upper bits ignored.
- Per bank, one round-robin arbiter over requesting DMA masters; rr pointer holds index of last winner, search starts at pointer+1 with wrap to 0. Pointer updates only on a grant.
- Exactly one DMA master granted per bank per cycle; losers see gnt=0 and must hold request.
- wl_gnt_o = wl_req_i always (port B never contends).
- Write: bytes with be=1 written; be=0 bytes retain content.
- Response for every granted request (read or write): r_valid one cycle later on the requester; rdata valid for reads only, undefined for writes.
- Read-first: read of a row written same cycle (same or other port) returns old data.
- Port A and port B write same row same cycle: port A bytes win where both be=1.
- Reset mid-operation: all r_valid/r_err cleared next edge, pointers reset; memory contents untouched; in-flight responses dropped.

## Timing
- Grant combinational from req/add in same cycle; no combinational path from gnt to req required.
- Read latency 1: data and r_valid on cycle after grant.
- Back-to-back requests to any bank sustained at one per cycle per port.
- Reset values: dma_r_valid_o, wl_r_valid_o, dma_r_err_o, wl_r_err_o = 0; rr pointers = NB_DMA_PORTS-1 (master 0 first). rdata undefined.
- Response routing uses registered granted-bank index per DMA master.

## Configuration
- WMEM_PARITY_EN defined: one even-parity bit stored per byte, written with the byte; on read, any mismatch asserts r_err with r_valid on that port. Unwritten rows may report errors.
- Undefined: no parity storage; dma_r_err_o and wl_r_err_o tied 0, ports kept.

## Structure
- hwce_wmem_pkg: address-split helper functions, bank/row width localparams, response-route struct (valid, bank index).
- Sub-module hwce_wmem_rr_arb: N-input round-robin arbiter with grant vector and winner index; instantiated per bank.
- Banks behavioural dual-port arrays inside the top.

## Test plan
- DMA0 writes 0xDEADBEEF to byte addr 0x10 (NB_BANKS=4 -> bank 0, row 1), wl_port0 reads row 1 -> rdata 0xDEADBEEF, r_valid one cycle later.
- DMA0 and DMA1 continuously read bank 2 -> grants alternate 0,1,0,1 from reset; each r_valid exactly one cycle after its grant.
- be=0b0011 write of 0x11223344 over 0xAAAAAAAA -> read returns 0xAAAA3344.
- Same-cycle port A write 0x1 and port B write 0x2 to same row, full be -> later read 0x1; same-cycle read on B returns pre-write value.
- rst_i asserted with reads in flight -> all r_valid 0 next cycle; previously written data still readable.
- WMEM_PARITY_EN: force flip of one stored bit -> read of that row gives r_err=1 with r_valid; without macro r_err stays 0.

Source files
------------

// File: rtl/hwce_wmem_pkg.sv
// hwce_wmem_pkg
// Shared types and helpers for the banked HWCE weight memory.
//   route_t      : per-DMA-master response route (valid + granted bank index)
//   idx_width    : index width for an N-way selection (never below 1)
//   byte_to_word : byte address -> word index
//   word_bank    : word index -> bank (low bits, interleaved)
//   word_row     : word index -> bank-local row (bits above the bank field)
// Optional feature macro used by the top: WMEM_PARITY_EN.
package hwce_wmem_pkg;

   // Route field is sized for the largest supported bank count so the
   // struct stays parameter-free; unused upper bits are always zero.
   localparam int unsigned BANK_IDX_W_MAX = 8;

   typedef struct packed {
      logic                      valid;
      logic [BANK_IDX_W_MAX-1:0] bank;
   } route_t;

   function automatic int unsigned idx_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   function automatic logic [63:0] byte_to_word(input logic [63:0] add,
                                                input int unsigned byte_ofs);
      return add >> byte_ofs;
   endfunction

   function automatic logic [63:0] word_bank(input logic [63:0] word,
                                             input int unsigned bank_w);
      return word & ((64'd1 << bank_w) - 64'd1);
   endfunction

   function automatic logic [63:0] word_row(input logic [63:0] word,
                                            input int unsigned bank_w,
                                            input int unsigned row_w);
      return (word >> bank_w) & ((64'd1 << row_w) - 64'd1);
   endfunction

endpackage

// File: rtl/hwce_wmem_banked_rr_arb.sv
// hwce_wmem_rr_arb
// N-input round-robin arbiter. The pointer holds the index of the last
// winner; the search starts one past it and wraps. Pointer moves only
// when something is granted.
//   clk_i, rst_i : clock, synchronous active-high reset
//   req          : request vector
//   gnt          : one-hot grant (combinational)
//   win_idx      : index of the granted requester
//   win_valid    : any grant this cycle
module hwce_wmem_rr_arb #(
   parameter int unsigned N     = 2,
   localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic [N-1:0]     req,
   output logic [N-1:0]     gnt,
   output logic [IDX_W-1:0] win_idx,
   output logic             win_valid
);

   logic [IDX_W-1:0] ptr_q;

   always_comb begin
      int cand;
      cand      = 0;
      gnt       = '0;
      win_idx   = '0;
      win_valid = 1'b0;
      for (int i = 1; i <= int'(N); i++) begin
         cand = int'(ptr_q) + i;
         if (cand >= int'(N)) cand = cand - int'(N);
         if (!win_valid && req[cand[IDX_W-1:0]]) begin
            win_valid                = 1'b1;
            win_idx                  = cand[IDX_W-1:0];
            gnt[cand[IDX_W-1:0]]     = 1'b1;
         end
      end
   end

   // Reset to the last index so master 0 is searched first.
   always_ff @(posedge clk_i) begin
      if (rst_i)          ptr_q <= IDX_W'(N - 1);
      else if (win_valid) ptr_q <= win_idx;
   end

endmodule

// File: rtl/hwce_wmem_banked.sv
// hwce_wmem_banked
// Word-interleaved HWCE weight memory. NB_BANKS dual-port banks; port A of
// each bank is shared by the DMA masters through a per-bank round-robin
// arbiter, port B of bank i belongs to weight-load port i.
//   clk_i, rst_i        : clock, synchronous active-high reset
//   dma_*               : DMA masters (byte address, wen=1 read / 0 write)
//   dma_gnt_o           : combinational grant, losers must hold request
//   dma_r_*             : response one cycle after grant, routed to requester
//   wl_*                : weight-load ports (bank-local row), never stalled
// Build option WMEM_PARITY_EN: even parity bit per byte, checked on read
// and reported on r_err together with r_valid. Without it r_err is 0.
module hwce_wmem_banked
   import hwce_wmem_pkg::*;
#(
   parameter int unsigned DATA_WIDTH   = 32,
   parameter int unsigned BANK_SIZE    = 256,
   parameter int unsigned NB_BANKS     = 4,
   parameter int unsigned NB_DMA_PORTS = 2,
   parameter int unsigned ADDR_WIDTH   = 32
) (
   input  logic                                        clk_i,
   input  logic                                        rst_i,
   input  logic [NB_DMA_PORTS-1:0]                     dma_req_i,
   input  logic [NB_DMA_PORTS-1:0]                     dma_wen_i,
   input  logic [NB_DMA_PORTS-1:0][ADDR_WIDTH-1:0]     dma_add_i,
   input  logic [NB_DMA_PORTS-1:0][DATA_WIDTH-1:0]     dma_wdata_i,
   input  logic [NB_DMA_PORTS-1:0][DATA_WIDTH/8-1:0]   dma_be_i,
   output logic [NB_DMA_PORTS-1:0]                     dma_gnt_o,
   output logic [NB_DMA_PORTS-1:0]                     dma_r_valid_o,
   output logic [NB_DMA_PORTS-1:0]                     dma_r_err_o,
   output logic [NB_DMA_PORTS-1:0][DATA_WIDTH-1:0]     dma_r_rdata_o,
   input  logic [NB_BANKS-1:0]                         wl_req_i,
   input  logic [NB_BANKS-1:0]                         wl_wen_i,
   input  logic [NB_BANKS-1:0][$clog2(BANK_SIZE)-1:0]  wl_add_i,
   input  logic [NB_BANKS-1:0][DATA_WIDTH-1:0]         wl_wdata_i,
   input  logic [NB_BANKS-1:0][DATA_WIDTH/8-1:0]       wl_be_i,
   output logic [NB_BANKS-1:0]                         wl_gnt_o,
   output logic [NB_BANKS-1:0]                         wl_r_valid_o,
   output logic [NB_BANKS-1:0]                         wl_r_err_o,
   output logic [NB_BANKS-1:0][DATA_WIDTH-1:0]         wl_r_rdata_o
);

   localparam int unsigned NB_BYTES   = DATA_WIDTH / 8;
   localparam int unsigned ROW_W      = $clog2(BANK_SIZE);
   localparam int unsigned BYTE_OFS   = $clog2(NB_BYTES);
   localparam int unsigned BANK_W     = $clog2(NB_BANKS);
   localparam int unsigned BANK_IDX_W = idx_width(NB_BANKS);
   localparam int unsigned MST_IDX_W  = idx_width(NB_DMA_PORTS);

   logic [NB_DMA_PORTS-1:0][BANK_IDX_W-1:0] dma_bank;
   logic [NB_DMA_PORTS-1:0][ROW_W-1:0]      dma_row;

   logic [NB_DMA_PORTS-1:0] bank_req [NB_BANKS];
   logic [NB_DMA_PORTS-1:0] bank_gnt [NB_BANKS];
   logic [MST_IDX_W-1:0]    bank_win [NB_BANKS];
   logic [NB_BANKS-1:0]     bank_any;

   logic [DATA_WIDTH-1:0]   a_rdata [NB_BANKS];
   logic [NB_BANKS-1:0]     a_err;

   route_t                  route_q [NB_DMA_PORTS];
   logic [NB_BANKS-1:0]     wl_r_valid_q;

   always_comb begin
      logic [63:0] word;
      word = '0;
      for (int p = 0; p < int'(NB_DMA_PORTS); p++) begin
         word        = byte_to_word(64'(dma_add_i[p]), BYTE_OFS);
         dma_bank[p] = BANK_IDX_W'(word_bank(word, BANK_W));
         dma_row[p]  = ROW_W'(word_row(word, BANK_W, ROW_W));
      end
   end

   always_comb begin
      for (int b = 0; b < int'(NB_BANKS); b++) begin
         bank_req[b] = '0;
         for (int p = 0; p < int'(NB_DMA_PORTS); p++)
            bank_req[b][p] = dma_req_i[p] && (dma_bank[p] == BANK_IDX_W'(b));
      end
   end

   // A master addresses one bank at a time, so OR-ing over banks is exact.
   always_comb begin
      dma_gnt_o = '0;
      for (int b = 0; b < int'(NB_BANKS); b++)
         dma_gnt_o = dma_gnt_o | bank_gnt[b];
   end

   assign wl_gnt_o     = wl_req_i;
   assign wl_r_valid_o = wl_r_valid_q;

   genvar b;
   generate
      for (b = 0; b < int'(NB_BANKS); b++) begin : g_bank
         logic [DATA_WIDTH-1:0] mem [BANK_SIZE];
         logic [DATA_WIDTH-1:0] a_rdata_q, b_rdata_q;
         logic [ROW_W-1:0]      a_row;
         logic [DATA_WIDTH-1:0] a_wdata;
         logic [NB_BYTES-1:0]   a_be;
         logic                  a_we, b_we;

         hwce_wmem_rr_arb #(.N(NB_DMA_PORTS)) u_arb (
            .clk_i     (clk_i),
            .rst_i     (rst_i),
            .req       (bank_req[b]),
            .gnt       (bank_gnt[b]),
            .win_idx   (bank_win[b]),
            .win_valid (bank_any[b])
         );

         assign a_row   = dma_row[bank_win[b]];
         assign a_wdata = dma_wdata_i[bank_win[b]];
         assign a_be    = dma_be_i[bank_win[b]];
         assign a_we    = bank_any[b] && !dma_wen_i[bank_win[b]];
         assign b_we    = wl_req_i[b] && !wl_wen_i[b];

         // Reads sample the array before this edge's writes land (read-first).
         // Port A is written after port B so A wins overlapping bytes.
         always_ff @(posedge clk_i) begin
            if (bank_any[b]) a_rdata_q <= mem[a_row];
            if (wl_req_i[b]) b_rdata_q <= mem[wl_add_i[b]];
            for (int i = 0; i < int'(NB_BYTES); i++) begin
               if (b_we && wl_be_i[b][i])
                  mem[wl_add_i[b]][i*8 +: 8] <= wl_wdata_i[b][i*8 +: 8];
               if (a_we && a_be[i])
                  mem[a_row][i*8 +: 8] <= a_wdata[i*8 +: 8];
            end
         end

         assign a_rdata[b]      = a_rdata_q;
         assign wl_r_rdata_o[b] = b_rdata_q;

`ifdef WMEM_PARITY_EN
         logic [NB_BYTES-1:0] par [BANK_SIZE];
         logic [NB_BYTES-1:0] a_par_q, b_par_q;
         logic [NB_BYTES-1:0] a_chk, b_chk;

         always_ff @(posedge clk_i) begin
            if (bank_any[b]) a_par_q <= par[a_row];
            if (wl_req_i[b]) b_par_q <= par[wl_add_i[b]];
            for (int i = 0; i < int'(NB_BYTES); i++) begin
               if (b_we && wl_be_i[b][i])
                  par[wl_add_i[b]][i] <= ^wl_wdata_i[b][i*8 +: 8];
               if (a_we && a_be[i])
                  par[a_row][i] <= ^a_wdata[i*8 +: 8];
            end
         end

         always_comb begin
            a_chk = '0;
            b_chk = '0;
            for (int i = 0; i < int'(NB_BYTES); i++) begin
               a_chk[i] = (^a_rdata_q[i*8 +: 8]) ^ a_par_q[i];
               b_chk[i] = (^b_rdata_q[i*8 +: 8]) ^ b_par_q[i];
            end
         end

         assign a_err[b]      = |a_chk;
         assign wl_r_err_o[b] = wl_r_valid_q[b] & (|b_chk);
`else
         assign a_err[b]      = 1'b0;
         assign wl_r_err_o[b] = 1'b0;
`endif
      end
   endgenerate

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wl_r_valid_q <= '0;
         for (int p = 0; p < int'(NB_DMA_PORTS); p++) route_q[p] <= '0;
      end else begin
         wl_r_valid_q <= wl_req_i;
         for (int p = 0; p < int'(NB_DMA_PORTS); p++) begin
            route_q[p].valid <= dma_gnt_o[p];
            route_q[p].bank  <= BANK_IDX_W_MAX'(dma_bank[p]);
         end
      end
   end

   always_comb begin
      dma_r_valid_o = '0;
      dma_r_err_o   = '0;
      dma_r_rdata_o = '0;
      for (int p = 0; p < int'(NB_DMA_PORTS); p++) begin
         dma_r_valid_o[p] = route_q[p].valid;
         for (int k = 0; k < int'(NB_BANKS); k++) begin
            if (route_q[p].bank == BANK_IDX_W_MAX'(k)) begin
               dma_r_rdata_o[p] = a_rdata[k];
               dma_r_err_o[p]   = route_q[p].valid & a_err[k];
            end
         end
      end
   end

endmodule

// File: tb/tb_hwce_wmem_banked.sv
// tb_hwce_wmem_banked
// Directed bench for hwce_wmem_banked at default parameters (4 banks of
// 256 x 32-bit words, 2 DMA masters). Inputs change 1 time unit after the
// rising edge; combinational grants are sampled 1 unit later, registered
// responses 1 unit after the following edge.
// Build option WMEM_PARITY_EN selects the parity-error scenario.
module tb_hwce_wmem_banked;

   localparam int unsigned DW = 32;
   localparam int unsigned BS = 256;
   localparam int unsigned NB = 4;
   localparam int unsigned ND = 2;
   localparam int unsigned AW = 32;
   localparam int unsigned RW = 8;

   logic                     clk_i = 1'b0;
   logic                     rst_i;
   logic [ND-1:0]            dma_req_i, dma_wen_i;
   logic [ND-1:0][AW-1:0]    dma_add_i;
   logic [ND-1:0][DW-1:0]    dma_wdata_i;
   logic [ND-1:0][DW/8-1:0]  dma_be_i;
   logic [ND-1:0]            dma_gnt_o, dma_r_valid_o, dma_r_err_o;
   logic [ND-1:0][DW-1:0]    dma_r_rdata_o;
   logic [NB-1:0]            wl_req_i, wl_wen_i;
   logic [NB-1:0][RW-1:0]    wl_add_i;
   logic [NB-1:0][DW-1:0]    wl_wdata_i;
   logic [NB-1:0][DW/8-1:0]  wl_be_i;
   logic [NB-1:0]            wl_gnt_o, wl_r_valid_o, wl_r_err_o;
   logic [NB-1:0][DW-1:0]    wl_r_rdata_o;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk_i = ~clk_i;

   hwce_wmem_banked #(
      .DATA_WIDTH(DW), .BANK_SIZE(BS), .NB_BANKS(NB),
      .NB_DMA_PORTS(ND), .ADDR_WIDTH(AW)
   ) dut (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .dma_req_i    (dma_req_i),
      .dma_wen_i    (dma_wen_i),
      .dma_add_i    (dma_add_i),
      .dma_wdata_i  (dma_wdata_i),
      .dma_be_i     (dma_be_i),
      .dma_gnt_o    (dma_gnt_o),
      .dma_r_valid_o(dma_r_valid_o),
      .dma_r_err_o  (dma_r_err_o),
      .dma_r_rdata_o(dma_r_rdata_o),
      .wl_req_i     (wl_req_i),
      .wl_wen_i     (wl_wen_i),
      .wl_add_i     (wl_add_i),
      .wl_wdata_i   (wl_wdata_i),
      .wl_be_i      (wl_be_i),
      .wl_gnt_o     (wl_gnt_o),
      .wl_r_valid_o (wl_r_valid_o),
      .wl_r_err_o   (wl_r_err_o),
      .wl_r_rdata_o (wl_r_rdata_o)
   );

   task automatic check_val(input string tag, input logic [31:0] got,
                            input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic idle();
      dma_req_i = '0;
      dma_wen_i = '1;
      wl_req_i  = '0;
      wl_wen_i  = '1;
   endtask

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   task automatic dma_set(input int p, input logic rd, input logic [31:0] add,
                          input logic [31:0] wd, input logic [3:0] be);
      dma_req_i[p]   = 1'b1;
      dma_wen_i[p]   = rd;
      dma_add_i[p]   = add;
      dma_wdata_i[p] = wd;
      dma_be_i[p]    = be;
   endtask

   task automatic wl_set(input int b, input logic rd, input logic [7:0] row,
                         input logic [31:0] wd, input logic [3:0] be);
      wl_req_i[b]   = 1'b1;
      wl_wen_i[b]   = rd;
      wl_add_i[b]   = row;
      wl_wdata_i[b] = wd;
      wl_be_i[b]    = be;
   endtask

   initial begin
      logic [31:0] exp_m;
      idle();
      dma_add_i   = '0;
      dma_wdata_i = '0;
      dma_be_i    = '0;
      wl_add_i    = '0;
      wl_wdata_i  = '0;
      wl_be_i     = '0;
      rst_i       = 1'b1;
      repeat (3) step();
      check_val("rst_dma_valid", 32'(dma_r_valid_o), 32'h0);
      check_val("rst_wl_valid",  32'(wl_r_valid_o),  32'h0);
      check_val("rst_dma_err",   32'(dma_r_err_o),   32'h0);
      check_val("rst_wl_err",    32'(wl_r_err_o),    32'h0);
      rst_i = 1'b0;
      step();

      // DMA0 writes byte 0x10 (bank 0, row 1); weight-load port 0 reads row 1
      dma_set(0, 1'b0, 32'h10, 32'hDEADBEEF, 4'hF);
      #1 check_val("wr_gnt", 32'(dma_gnt_o), 32'h1);
      step();
      check_val("wr_rvalid", 32'(dma_r_valid_o), 32'h1);
      idle();
      wl_set(0, 1'b1, 8'd1, 32'h0, 4'h0);
      #1 check_val("wl_gnt", 32'(wl_gnt_o), 32'h1);
      step();
      check_val("wl_rvalid", 32'(wl_r_valid_o), 32'h1);
      check_val("wl_rdata",  wl_r_rdata_o[0],   32'hDEADBEEF);
      idle();

      // Preload bank 2 rows 0 and 1 through weight-load port 2
      wl_set(2, 1'b0, 8'd0, 32'h22220000, 4'hF);
      step();
      idle();
      wl_set(2, 1'b0, 8'd1, 32'h22221111, 4'hF);
      step();
      idle();

      // Both DMA masters hammer bank 2: grants alternate 0,1,0,1,0
      dma_set(0, 1'b1, 32'h08, 32'h0, 4'h0);
      dma_set(1, 1'b1, 32'h18, 32'h0, 4'h0);
      for (int k = 0; k < 5; k++) begin
         exp_m = (k % 2 == 0) ? 32'h1 : 32'h2;
         #1 check_val("rr_gnt", 32'(dma_gnt_o), exp_m);
         step();
         check_val("rr_rvalid", 32'(dma_r_valid_o), exp_m);
         if (k % 2 == 0) check_val("rr_rdata0", dma_r_rdata_o[0], 32'h22220000);
         else            check_val("rr_rdata1", dma_r_rdata_o[1], 32'h22221111);
      end
      idle();

      // Byte-enable merge on bank 3 row 5 (byte 0x5C)
      dma_set(1, 1'b0, 32'h5C, 32'hAAAAAAAA, 4'hF);
      step();
      idle();
      dma_set(1, 1'b0, 32'h5C, 32'h11223344, 4'b0011);
      step();
      idle();
      dma_set(1, 1'b1, 32'h5C, 32'h0, 4'h0);
      step();
      check_val("be_rvalid", 32'(dma_r_valid_o), 32'h2);
      check_val("be_rdata",  dma_r_rdata_o[1],   32'hAAAA3344);
      idle();

      // Bank 1 row 7 (byte 0x74): A/B write collision, then read-first both ways
      wl_set(1, 1'b0, 8'd7, 32'h55, 4'hF);
      step();
      idle();
      dma_set(0, 1'b0, 32'h74, 32'h1, 4'hF);
      wl_set(1, 1'b0, 8'd7, 32'h2, 4'hF);
      step();
      idle();
      dma_set(0, 1'b0, 32'h74, 32'h3, 4'hF);
      wl_set(1, 1'b1, 8'd7, 32'h0, 4'h0);
      step();
      check_val("coll_b_old", wl_r_rdata_o[1], 32'h1);
      idle();
      dma_set(0, 1'b1, 32'h74, 32'h0, 4'h0);
      wl_set(1, 1'b0, 8'd7, 32'h4, 4'hF);
      step();
      check_val("coll_a_old", dma_r_rdata_o[0], 32'h3);
      idle();
      wl_set(1, 1'b1, 8'd7, 32'h0, 4'h0);
      step();
      check_val("coll_b_new", wl_r_rdata_o[1], 32'h4);
      idle();

      // Reset with responses in flight; bank 2 pointer was left on master 0
      dma_set(0, 1'b1, 32'h10, 32'h0, 4'h0);
      dma_set(1, 1'b1, 32'h5C, 32'h0, 4'h0);
      wl_set(0, 1'b1, 8'd1, 32'h0, 4'h0);
      step();
      check_val("pre_rst_dma_valid", 32'(dma_r_valid_o), 32'h3);
      check_val("pre_rst_wl_valid",  32'(wl_r_valid_o),  32'h1);
      rst_i = 1'b1;
      step();
      check_val("mid_rst_dma_valid", 32'(dma_r_valid_o), 32'h0);
      check_val("mid_rst_wl_valid",  32'(wl_r_valid_o),  32'h0);
      rst_i = 1'b0;
      idle();
      dma_set(0, 1'b1, 32'h08, 32'h0, 4'h0);
      dma_set(1, 1'b1, 32'h18, 32'h0, 4'h0);
      #1 check_val("rst_ptr_gnt", 32'(dma_gnt_o), 32'h1);
      step();
      idle();
      dma_set(0, 1'b1, 32'h10, 32'h0, 4'h0);
      wl_set(0, 1'b1, 8'd1, 32'h0, 4'h0);
      step();
      check_val("keep_dma_rdata", dma_r_rdata_o[0], 32'hDEADBEEF);
      check_val("keep_wl_rdata",  wl_r_rdata_o[0],  32'hDEADBEEF);
      idle();

`ifdef WMEM_PARITY_EN
      dma_set(0, 1'b1, 32'h10, 32'h0, 4'h0);
      step();
      check_val("par_clean_err", 32'(dma_r_err_o), 32'h0);
      idle();
      dut.g_bank[0].mem[1][0] = ~dut.g_bank[0].mem[1][0];
      dma_set(0, 1'b1, 32'h10, 32'h0, 4'h0);
      wl_set(0, 1'b1, 8'd1, 32'h0, 4'h0);
      step();
      check_val("par_dma_valid", 32'(dma_r_valid_o), 32'h1);
      check_val("par_dma_err",   32'(dma_r_err_o),   32'h1);
      check_val("par_wl_err",    32'(wl_r_err_o),    32'h1);
      idle();
`else
      dma_set(0, 1'b1, 32'h10, 32'h0, 4'h0);
      wl_set(0, 1'b1, 8'd1, 32'h0, 4'h0);
      step();
      check_val("nopar_dma_valid", 32'(dma_r_valid_o), 32'h1);
      check_val("nopar_dma_err",   32'(dma_r_err_o),   32'h0);
      check_val("nopar_wl_err",    32'(wl_r_err_o),    32'h0);
      idle();
`endif

      step();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
